// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam int LATENCY_MIN = 1;
  localparam int WORD_BYTES  = 4;
  localparam int WORD_W      = WORD_BYTES * 8;

  // Bits needed to index an array of the given depth (at least one bit).
  function automatic int index_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response channels between the core's load/store path and the responder.
interface dmem_responder_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_W-1:0]     req_addr;
  logic                  req_wen;
  logic [WORD_W-1:0]     req_wdata;
  logic [WORD_BYTES-1:0] req_wmask;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [WORD_W-1:0]     resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wmask, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_sram_array.sv
// Single-port word array with byte write enables and registered read data.
module dmem_sram_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  wen,
  input  logic [IDX_W-1:0]      idx,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [WORD_BYTES-1:0] wmask,
  output logic [WORD_W-1:0]     rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  // Enabled access: merge the selected bytes on a write, capture the word on a read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (wen) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
          if (wmask[b]) begin
            mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, response after a fixed latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input logic       clk,
  input logic       rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = index_width(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);

  state_t                state;
  logic                  ready_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  rd_ok_q;
  logic [CNT_W-1:0]      cnt;
  logic [ADDR_W-1:0]     addr_q;
  logic                  wen_q;
  logic [WORD_W-1:0]     wdata_q;
  logic [WORD_BYTES-1:0] wmask_q;

  logic                  accept;
  logic                  commit;
  logic                  in_range;
  logic                  mem_en;
  logic [ADDR_W-1:0]     sel_addr;
  logic                  sel_wen;
  logic [WORD_W-1:0]     sel_wdata;
  logic [WORD_BYTES-1:0] sel_wmask;
  logic [IDX_W-1:0]      sel_idx;
  logic [WORD_W-1:0]     mem_rdata;

  // Pick the live request in IDLE (a one-cycle latency commits on the accept edge), the latched one otherwise.
  always_comb begin
    accept    = (state == IDLE) && ready_q && bus.req_valid;
    sel_addr  = addr_q;
    sel_wen   = wen_q;
    sel_wdata = wdata_q;
    sel_wmask = wmask_q;
    if (state == IDLE) begin
      sel_addr  = bus.req_addr;
      sel_wen   = bus.req_wen;
      sel_wdata = bus.req_wdata;
      sel_wmask = bus.req_wmask;
    end
    in_range = (sel_addr >> (IDX_W + 2)) == '0;
    commit   = ((state == WAIT) && (cnt == CNT_W'(1))) || (accept && (LATENCY == 1));
    mem_en   = commit && in_range;
    sel_idx  = sel_addr[IDX_W+1:2];
  end

  dmem_sram_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk  (clk),
    .en   (mem_en),
    .wen  (sel_wen),
    .idx  (sel_idx),
    .wdata(sel_wdata),
    .wmask(sel_wmask),
    .rdata(mem_rdata)
  );

  // Sequence accept, latency countdown and response handshake with registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
      cnt     <= '0;
      addr_q  <= '0;
      wen_q   <= 1'b0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            addr_q  <= bus.req_addr;
            wen_q   <= bus.req_wen;
            wdata_q <= bus.req_wdata;
            wmask_q <= bus.req_wmask;
            ready_q <= 1'b0;
            if (LATENCY > 1) begin
              state <= WAIT;
              cnt   <= CNT_W'(LATENCY - 1);
            end else begin
              state   <= RESP;
              valid_q <= 1'b1;
              err_q   <= !in_range;
              rd_ok_q <= in_range && !bus.req_wen;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state   <= RESP;
            valid_q <= 1'b1;
            err_q   <= !in_range;
            rd_ok_q <= in_range && !wen_q;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            rd_ok_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = valid_q;
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rd_ok_q ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: table vectors, randomized traffic against a word-array model, latency/reset corners.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic s_rst;

  int n_vec  = 0;
  int n_miss = 0;

  logic        s_req_valid;
  logic        s_wen;
  logic        s_resp_ready;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wmask;

  dmem_responder_if #(.ADDR_W(32)) bus ();
  dmem_responder_if #(.ADDR_W(32)) bus1 ();
  dmem_responder_if #(.ADDR_W(32)) bus4 ();
  dmem_responder_if #(.ADDR_W(32)) bus5 ();

  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(2)) dut  (.clk(clk), .rst(rst),   .bus(bus));
  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(1)) dut1 (.clk(clk), .rst(s_rst), .bus(bus1));
  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(4)) dut4 (.clk(clk), .rst(s_rst), .bus(bus4));
  dmem_responder #(.ADDR_W(32), .DEPTH_WORDS(DEPTH), .LATENCY(5)) dut5 (.clk(clk), .rst(s_rst), .bus(bus5));

  assign bus1.req_valid  = s_req_valid;
  assign bus1.req_addr   = s_addr;
  assign bus1.req_wen    = s_wen;
  assign bus1.req_wdata  = s_wdata;
  assign bus1.req_wmask  = s_wmask;
  assign bus1.resp_ready = s_resp_ready;
  assign bus4.req_valid  = s_req_valid;
  assign bus4.req_addr   = s_addr;
  assign bus4.req_wen    = s_wen;
  assign bus4.req_wdata  = s_wdata;
  assign bus4.req_wmask  = s_wmask;
  assign bus4.resp_ready = s_resp_ready;
  assign bus5.req_valid  = s_req_valid;
  assign bus5.req_addr   = s_addr;
  assign bus5.req_wen    = s_wen;
  assign bus5.req_wdata  = s_wdata;
  assign bus5.req_wmask  = s_wmask;
  assign bus5.resp_ready = s_resp_ready;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  // Free-running clock.
  always #5 clk = ~clk;

  // Stop a stuck run with a visible failure.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One complete transaction on the LATENCY=2 responder, holding resp_ready low for 'hold' response cycles.
  task automatic apply_stimulus(input logic [31:0] addr, input logic wen, input logic [31:0] wdata,
                                input logic [3:0] wmask, input int hold,
                                output logic [31:0] rdata, output logic err, output int lat);
    int          n;
    logic [31:0] r0;
    logic        e0;
    rdata = '0;
    err   = 1'b0;
    lat   = 0;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_wen    = wen;
    bus.req_wdata  = wdata;
    bus.req_wmask  = wmask;
    bus.resp_ready = (hold == 0);
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      check_output("req_ready timeout", 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wen   = 1'($urandom);
    bus.req_wdata = $urandom;
    bus.req_wmask = 4'($urandom);
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.resp_valid && lat < 50);
    if (!bus.resp_valid) begin
      check_output("resp_valid timeout", 32'(bus.resp_valid), 32'd1);
      bus.resp_ready = 1'b1;
      return;
    end
    rdata = bus.resp_rdata;
    err   = bus.resp_err;
    r0    = rdata;
    e0    = err;
    for (int h = 0; h < hold; h++) begin
      check_output("hold req_ready", 32'(bus.req_ready), 32'd0);
      @(negedge clk);
      check_output("hold resp_valid", 32'(bus.resp_valid), 32'd1);
      check_output("hold rdata stable", bus.resp_rdata, r0);
      check_output("hold err stable", 32'(bus.resp_err), 32'(e0));
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check_output("post resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("post req_ready", 32'(bus.req_ready), 32'd1);
  endtask

  // Main test sequence.
  initial begin
    vec_t        vecs[$];
    logic [31:0] model[16];
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          lats[3];
    int          first[3];
    int          prev[3];
    int          gmin[3];
    int          gmax[3];
    logic [31:0] cap[3];
    logic [2:0]  sv;
    logic        saw_valid;

    lats = '{1, 4, 5};
    rst = 1'b0;
    s_rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_addr = '0;
    bus.req_wen = 1'b0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.resp_ready = 1'b1;
    s_req_valid = 1'b0;
    s_addr = '0;
    s_wen = 1'b0;
    s_wdata = '0;
    s_wmask = '0;
    s_resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_output("reset req_ready", 32'(bus.req_ready), 32'd0);
    check_output("reset resp_valid", 32'(bus.resp_valid), 32'd0);
    check_output("reset resp_err", 32'(bus.resp_err), 32'd0);
    check_output("reset resp_rdata", bus.resp_rdata, 32'd0);
    check_output("reset req_ready L4", 32'(bus4.req_ready), 32'd0);
    rst = 1'b1;
    s_rst = 1'b1;
    @(negedge clk);
    check_output("release req_ready", 32'(bus.req_ready), 32'd1);
    check_output("release req_ready L1", 32'(bus1.req_ready), 32'd1);
    check_output("release req_ready L5", 32'(bus5.req_ready), 32'd1);

    vecs.push_back('{32'h0000_0000, 1'b1, 32'h0BAD_F00D, 4'hF, 0, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_0010, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{32'h0000_0020, 1'b1, 32'h1122_3344, 4'hF, 0, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_0020, 1'b1, 32'hAABB_CCDD, 4'h5, 0, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_0020, 1'b0, 32'h0,         4'h0, 0, 32'h11BB_33DD, 1'b0});
    vecs.push_back('{32'h0000_0020, 1'b1, 32'hFFFF_FFFF, 4'h0, 0, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_0020, 1'b0, 32'h0,         4'h0, 1, 32'h11BB_33DD, 1'b0});
    vecs.push_back('{32'h0000_0010, 1'b0, 32'h0,         4'h0, 5, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{32'h0000_1000, 1'b0, 32'h0,         4'h0, 0, 32'h0, 1'b1});
    vecs.push_back('{32'h0000_1000, 1'b1, 32'h5555_5555, 4'hF, 0, 32'h0, 1'b1});
    vecs.push_back('{32'h0000_0000, 1'b0, 32'h0,         4'h0, 0, 32'h0BAD_F00D, 1'b0});
    vecs.push_back('{32'h0000_0013, 1'b0, 32'h0,         4'h0, 0, 32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{32'h0000_0FFC, 1'b1, 32'h0F0F_0F0F, 4'hF, 0, 32'h0, 1'b0});
    vecs.push_back('{32'h0000_0FFE, 1'b0, 32'h0,         4'h0, 2, 32'h0F0F_0F0F, 1'b0});
    vecs.push_back('{32'hFFFF_FFFC, 1'b0, 32'h0,         4'h0, 0, 32'h0, 1'b1});
    vecs.push_back('{32'h0000_1FFC, 1'b1, 32'h1234_0000, 4'hC, 0, 32'h0, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i].addr, vecs[i].wen, vecs[i].wdata, vecs[i].wmask, vecs[i].hold, rd, er, lat);
      check_output($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      check_output($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].exp_err));
      check_output($sformatf("vec%0d latency", i), 32'(lat), 32'd2);
    end

    for (int w = 0; w < 16; w++) begin
      model[w] = $urandom;
      apply_stimulus(32'(w * 4), 1'b1, model[w], 4'hF, 0, rd, er, lat);
      check_output("init write err", 32'(er), 32'd0);
    end
    for (int t = 0; t < 150; t++) begin
      int          w;
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp_r;
      logic        exp_e;
      w     = $urandom_range(0, 15);
      wen   = 1'($urandom);
      wdata = $urandom;
      wmask = 4'($urandom);
      if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h0000_1000;
      else addr = 32'(w * 4 + $urandom_range(0, 3));
      exp_r = '0;
      exp_e = 1'b0;
      if ((addr >> 2) >= DEPTH) begin
        exp_e = 1'b1;
      end else if (wen) begin
        for (int b = 0; b < 4; b++) begin
          if (wmask[b]) model[w][b*8 +: 8] = wdata[b*8 +: 8];
        end
      end else begin
        exp_r = model[w];
      end
      apply_stimulus(addr, wen, wdata, wmask, $urandom_range(0, 2), rd, er, lat);
      check_output($sformatf("rand%0d rdata", t), rd, exp_r);
      check_output($sformatf("rand%0d err", t), 32'(er), 32'(exp_e));
      check_output($sformatf("rand%0d latency", t), 32'(lat), 32'd2);
    end

    @(negedge clk);
    s_addr = 32'h40;
    s_wen = 1'b0;
    s_req_valid = 1'b1;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    first = '{0, 0, 0};
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      sv = {bus5.resp_valid, bus4.resp_valid, bus1.resp_valid};
      for (int i = 0; i < 3; i++) begin
        if (sv[i] && first[i] == 0) first[i] = c;
      end
    end
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("latency L%0d", lats[i]), 32'(first[i]), 32'(lats[i]));
    end

    @(negedge clk);
    s_req_valid = 1'b1;
    prev = '{-1, -1, -1};
    gmin = '{1000, 1000, 1000};
    gmax = '{0, 0, 0};
    for (int c = 0; c < 40; c++) begin
      sv = {bus5.req_ready, bus4.req_ready, bus1.req_ready};
      for (int i = 0; i < 3; i++) begin
        if (sv[i]) begin
          if (prev[i] >= 0) begin
            if (c - prev[i] < gmin[i]) gmin[i] = c - prev[i];
            if (c - prev[i] > gmax[i]) gmax[i] = c - prev[i];
          end
          prev[i] = c;
        end
      end
      @(negedge clk);
    end
    s_req_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_output($sformatf("min spacing L%0d", lats[i]), 32'(gmin[i]), 32'(lats[i] + 1));
      check_output($sformatf("max spacing L%0d", lats[i]), 32'(gmax[i]), 32'(lats[i] + 1));
    end
    repeat (10) @(negedge clk);

    s_wen = 1'b1;
    s_addr = 32'h30;
    s_wdata = 32'h1234_5678;
    s_wmask = 4'hF;
    s_req_valid = 1'b1;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    repeat (10) @(negedge clk);
    s_wdata = 32'hCAFE_BABE;
    s_req_valid = 1'b1;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    s_wdata = $urandom;
    s_wmask = 4'($urandom);
    @(negedge clk);
    saw_valid = bus4.resp_valid;
    @(posedge clk);
    @(negedge clk);
    saw_valid = saw_valid | bus4.resp_valid;
    @(posedge clk);
    #1;
    s_rst = 1'b0;
    @(negedge clk);
    check_output("midwait reset req_ready L4", 32'(bus4.req_ready), 32'd0);
    @(negedge clk);
    s_rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      saw_valid = saw_valid | bus4.resp_valid;
    end
    check_output("midwait no response L4", 32'(saw_valid), 32'd0);

    s_wen = 1'b0;
    s_addr = 32'h30;
    s_req_valid = 1'b1;
    @(posedge clk);
    #1;
    s_req_valid = 1'b0;
    cap = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus1.resp_valid) cap[0] = bus1.resp_rdata;
      if (bus4.resp_valid) cap[1] = bus4.resp_rdata;
      if (bus5.resp_valid) cap[2] = bus5.resp_rdata;
    end
    check_output("after reset read L1", cap[0], 32'hCAFE_BABE);
    check_output("after reset read L4", cap[1], 32'h1234_5678);
    check_output("after reset read L5", cap[2], 32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
